// File: rtl/slow_hold_pkg.sv
// Shared constants for the slow-mode hold logic: FSM encodings and the device
// index order, which matches the bit order of the slow-device config register.
package slow_hold_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_COUNT = 2'd2;

  localparam int DEV_IACK = 0;
  localparam int DEV_VIA  = 1;
  localparam int DEV_IWM  = 2;
  localparam int DEV_SCC  = 3;
  localparam int DEV_SCSI = 4;
  localparam int DEV_SND  = 5;
  localparam int NUM_DEV  = 6;
endpackage

// File: rtl/slow_tick.sv
// Timeout prescaler: counts 0..TICK_DIV-1 while enabled, held at 0 while cleared.
// Tick is a one-cycle pulse on the last prescaler value.
module slow_tick #(
  parameter int TICK_DIV = 64
) (
  input  logic CLK,
  input  logic nPOR,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    if (clr)
      pre_d = '0;
    else if (en)
      pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR)
      pre_q <= '0;
    else
      pre_q <= pre_d;
  end

  assign tick = en && !clr && (pre_q == LAST);
endmodule

// File: rtl/slow_hold.sv
// Holds the accelerator in slow mode while an access hits a slow-enabled device,
// then for SlowTimeout ticks of TICK_DIV cycles after the access ends.
module slow_hold
  import slow_hold_pkg::*;
#(
  parameter int TICK_DIV = 64
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       SlowReq,
  output logic       ClockGateReq,
  output logic [1:0] SlowState
);
  logic [NUM_DEV-1:0] dev_cs, dev_slow;
  logic               hit, tick;
  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               slow_req_q, cg_req_q;

  assign dev_cs[DEV_IACK]   = IACKCS;
  assign dev_cs[DEV_VIA]    = VIACS;
  assign dev_cs[DEV_IWM]    = IWMCS;
  assign dev_cs[DEV_SCC]    = SCCCS;
  assign dev_cs[DEV_SCSI]   = SCSICS;
  assign dev_cs[DEV_SND]    = SndCS;
  assign dev_slow[DEV_IACK] = SlowIACK;
  assign dev_slow[DEV_VIA]  = SlowVIA;
  assign dev_slow[DEV_IWM]  = SlowIWM;
  assign dev_slow[DEV_SCC]  = SlowSCC;
  assign dev_slow[DEV_SCSI] = SlowSCSI;
  assign dev_slow[DEV_SND]  = SlowSnd;

  assign hit = BACT && |(dev_cs & dev_slow);

  slow_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .nPOR (nPOR),
    .clr  (state_q != ST_COUNT),
    .en   (state_q == ST_COUNT),
    .tick (tick)
  );

  // A hit in COUNT beats a coincident final tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_HOLD;
      ST_HOLD: begin
        if (!BACT) begin
          if (SlowTimeout == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COUNT;
            cnt_d   = SlowTimeout;
          end
        end
      end
      ST_COUNT: begin
        if (hit) begin
          state_d = ST_HOLD;
          cnt_d   = 4'd0;
        end else if (tick) begin
          if (cnt_q == 4'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      slow_req_q <= 1'b0;
      cg_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      slow_req_q <= (state_d != ST_IDLE);
      cg_req_q   <= (state_d != ST_IDLE) && SlowClockGate;
    end
  end

  assign SlowReq      = slow_req_q;
  assign ClockGateReq = cg_req_q;
  assign SlowState    = state_q;
endmodule

// File: doc/slow_hold.md
# slow_hold

Downstream consumer of the slow-device configuration register. Watches each bus access and, when it hits a device whose Slow* enable bit is set, holds the accelerator in slow mode for the rest of the access. Slow mode stays on for a programmable timeout after the access ends. Drives the slow-request and clock-gate-request lines seen by the bus/clock control logic.

## Interface
- TICK_DIV, 64: CLK cycles per timeout tick; legal 2..256.
- CLK  in  1  system clock; all state on rising edge
- nPOR  in  1  asynchronous active-low reset
- BACT  in  1  bus access active; high for the whole access
- IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS  in  1 each  decoded device selects, valid whenever BACT=1
- SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd  in  1 each  per-device slow enables from the config register
- SlowClockGate  in  1  config bit that requests clock gating while slow
- SlowTimeout  in  4  timeout length in ticks (0..15)
- SlowReq  out  1  registered; accelerator must run slow
- ClockGateReq  out  1  registered; gate fast clock
- SlowState  out  2  current FSM state, for debug and bench observation

## Operation
- Hit = BACT && OR over devices of (xxxCS && SlowXxx).
- FSM states are IDLE=0, HOLD=1, COUNT=2; encoding 3 is unused and recovers to IDLE.
- IDLE: on Hit, go to HOLD.
- HOLD: stays while BACT=1, whatever the Hit or enable bits do. When BACT is sampled 0:
  - SlowTimeout==0: go to IDLE.
  - Otherwise: go to COUNT, load Cnt=SlowTimeout, clear the prescaler.
- COUNT:
  - On Hit: go to HOLD; Cnt is discarded.
  - A non-hit access (BACT=1 with Hit=0) has no effect; counting continues.
  - On tick with Cnt==1: go to IDLE.
  - Otherwise on tick: Cnt decrements.
- Tick: the prescaler counts 0..TICK_DIV-1 in COUNT only and wraps. Tick = prescaler at TICK_DIV-1. The prescaler is held at 0 outside COUNT.
- SlowTimeout is sampled only at the HOLD->COUNT load. Later changes do not affect a running count.
- SlowReq = (state != IDLE), registered from next-state.
- ClockGateReq = (next-state != IDLE) && SlowClockGate, registered. SlowClockGate is sampled every cycle, so clearing it drops ClockGateReq one cycle later even while slow.
- Reset (async, any state): state=IDLE, Cnt=0, prescaler=0, SlowReq=0, ClockGateReq=0, SlowState=0.
- Reset released during an access: no Hit is missed. If BACT && hit is sampled on the first active edge, go to HOLD.

## Timing
- Hit sampled at edge n: SlowReq=1 from edge n (visible in cycle n+1). Latency is 1 cycle.
- BACT sampled 0 at edge m, SlowTimeout=T>0: SlowReq falls at edge m + T*TICK_DIV exactly.
- BACT sampled 0 at edge m, T=0: SlowReq falls at edge m.
- Back-to-back accesses are seen as BACT going 0 for at least 1 cycle. A Hit on the first cycle of COUNT returns to HOLD with no SlowReq glitch.
- Hit and the final tick on the same edge: Hit wins; next state is HOLD.
- Cnt is 4 bits and never wraps below 1 in COUNT. The prescaler is ceil(log2(TICK_DIV)) bits.

## Structure
- Shared include holds the state localparams (IDLE, HOLD, COUNT) and the device-index order IACK, VIA, IWM, SCC, SCSI, Snd. That order matches the config-register bit order.
- One sub-module, slow_tick: prescaler with clear/enable inputs and a one-cycle tick output.
- The top holds the hit OR, the FSM, Cnt and the output registers.

## Test plan
- Bench uses TICK_DIV=4.
- Reset defaults (SlowVIA=1, SlowSCC=0, T=15): VIA access for 3 cycles → SlowReq rises 1 cycle after the access starts and falls exactly 60 cycles after BACT is sampled low. An SCC access → SlowReq stays 0.
- T=0, SlowSCSI=1: SCSI access → SlowReq high only during the access; state goes HOLD→IDLE; ClockGateReq stays 0 with SlowClockGate=0.
- T=3: VIA access. After 5 COUNT cycles, a second VIA access → state returns to HOLD. After the second access ends, SlowReq falls 12 cycles later.
- T=2: IWM access with SlowIWM=1. During COUNT, an SCC access with SlowSCC=0 → the count is unaffected and SlowReq falls 8 cycles after the first access.
- SlowClockGate=1, T=5: Snd access → ClockGateReq tracks SlowReq. Clear SlowClockGate mid-COUNT → ClockGateReq falls 1 cycle later while SlowReq holds. Change SlowTimeout mid-COUNT → no effect.
- Assert nPOR mid-COUNT (async, between edges) → SlowReq and ClockGateReq go 0 immediately. Release with BACT=1 on a VIA hit → HOLD on the first edge.
